// File: rtl/adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_capture
// Function : SAR ADC front end: divided conversion clock, per-conversion
//            sample capture, sample FIFO with valid/ready output and sticky
//            overflow. Optional decimating accumulator under ADC_DECIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_capture #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DECIM_LOG2 = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    output logic                          adc_clk,
    input  logic [DATA_W-1:0]             adc_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int c_CNT_W  = $clog2(CLK_DIV);
    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_cnt_last = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_cnt_half = c_CNT_W'(CLK_DIV / 2);
    localparam logic [c_ADDR_W:0]   c_full     = (c_ADDR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Conversion clock divider
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_adc_clk;
    logic               w_stb;

    always_comb begin
        w_cnt_next = '0;
        if (enable && (r_cnt != c_cnt_last))
            w_cnt_next = r_cnt + 1'b1;
    end

    // Strobe lands on the last low-phase cycle, just before adc_clk rises.
    assign w_stb = enable & (r_cnt == c_cnt_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_adc_clk <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_adc_clk <= enable & (w_cnt_next < c_cnt_half);
        end
    end

    assign adc_clk = r_adc_clk;

    // ------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_cap;
    logic              r_push_pend;

`ifdef ADC_DECIM_EN
    localparam int c_ACC_W = DATA_W + DECIM_LOG2;

    logic [c_ACC_W-1:0]    r_acc;
    logic [DECIM_LOG2-1:0] r_dcnt;
    logic [c_ACC_W-1:0]    w_acc_sum;

    assign w_acc_sum = r_acc + c_ACC_W'(adc_data);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc       <= '0;
            r_dcnt      <= '0;
            r_cap       <= '0;
            r_push_pend <= 1'b0;
        end else begin
            r_push_pend <= 1'b0;
            if (!enable) begin
                r_acc  <= '0;
                r_dcnt <= '0;
            end else if (w_stb) begin
                // Final sample of the group: the averaged result goes out and
                // the accumulator restarts on the same edge.
                if (r_dcnt == '1) begin
                    r_cap       <= DATA_W'(w_acc_sum >> DECIM_LOG2);
                    r_push_pend <= 1'b1;
                    r_acc       <= '0;
                    r_dcnt      <= '0;
                end else begin
                    r_acc  <= w_acc_sum;
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap       <= '0;
            r_push_pend <= 1'b0;
        end else begin
            r_push_pend <= w_stb;
            if (w_stb)
                r_cap <= adc_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_level;
    logic                r_overflow;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign out_valid = (r_level != '0);
    assign w_full    = (r_level == c_full);
    assign w_pop     = out_valid & out_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer sits.
    assign w_push    = r_push_pend & (~w_full | w_pop);
    assign w_drop    = r_push_pend & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (!reset && w_push)
            r_mem[r_wr_ptr] <= r_cap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clear_overflow)
                r_overflow <= 1'b0;
        end
    end

    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_capture
// Function : Randomized self-checking bench for adc_sample_capture against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_capture;

    localparam int DATA_W     = 8;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DECIM_LOG2 = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              adc_clk;
    logic [DATA_W-1:0] adc_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        fifo_level;
    logic              overflow;
    logic              clear_overflow;

    always #5 clock = ~clock;

    adc_sample_capture #(
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DECIM_LOG2(DECIM_LOG2)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .adc_clk       (adc_clk),
        .adc_data      (adc_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: conversion phase, one pending sample, FIFO as a queue.
    int               m_phase;
    bit               m_pend;
    logic [DATA_W-1:0] m_pend_val;
    logic [DATA_W-1:0] m_q[$];
    bit               m_ovf;
    bit               m_adc;
    int               m_sum;
    int               m_n;

    task automatic model_step();
        bit drop;
        bit strobe;
        drop = 1'b0;
        if (reset) begin
            m_phase = 0;
            m_pend  = 1'b0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_adc   = 1'b0;
            m_sum   = 0;
            m_n     = 0;
        end else begin
            if (m_q.size() > 0 && out_ready)
                void'(m_q.pop_front());
            if (m_pend) begin
                if (m_q.size() < FIFO_DEPTH)
                    m_q.push_back(m_pend_val);
                else
                    drop = 1'b1;
            end
            if (drop)
                m_ovf = 1'b1;
            else if (clear_overflow)
                m_ovf = 1'b0;
            strobe = enable && (m_phase == CLK_DIV - 1);
            m_pend = 1'b0;
`ifdef ADC_DECIM_EN
            if (!enable) begin
                m_sum = 0;
                m_n   = 0;
            end else if (strobe) begin
                m_sum += int'(adc_data);
                m_n++;
                if (m_n == (1 << DECIM_LOG2)) begin
                    m_pend     = 1'b1;
                    m_pend_val = DATA_W'(m_sum >> DECIM_LOG2);
                    m_sum      = 0;
                    m_n        = 0;
                end
            end
`else
            if (strobe) begin
                m_pend     = 1'b1;
                m_pend_val = adc_data;
            end
`endif
            m_phase = enable ? (m_phase + 1) % CLK_DIV : 0;
            m_adc   = enable && (m_phase < CLK_DIV / 2);
        end
    endtask

    task automatic cycle();
        logic [DATA_W-1:0] exp_data;
        model_step();
        @(posedge clock);
        #1;
        exp_data = (m_q.size() > 0) ? m_q[0] : '0;
        chk("adc_clk",    adc_clk,    m_adc);
        chk("out_valid",  out_valid,  m_q.size() != 0);
        chk("fifo_level", fifo_level, m_q.size());
        chk("out_data",   out_data,   exp_data);
        chk("overflow",   overflow,   m_ovf);
    endtask

    initial begin
        int ready_pct;
        reset          = 1'b1;
        enable         = 1'b0;
        adc_data       = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) cycle();

        // Steady streaming of a constant value with an always-ready consumer.
        reset     = 1'b0;
        enable    = 1'b1;
        adc_data  = 8'hA5;
        out_ready = 1'b1;
        repeat (40) cycle();

        // Ramp into a stalled consumer: fills, then drops and flags overflow.
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 11 * CLK_DIV; k++) begin
            adc_data = DATA_W'(k / CLK_DIV);
            cycle();
        end
        chk("ramp_full", fifo_level, 4'd8);
        chk("ramp_ovf",  overflow,   1'b1);

        // Stop conversions and drain; overflow cleared once.
        enable         = 1'b0;
        out_ready      = 1'b1;
        clear_overflow = 1'b1;
        cycle();
        clear_overflow = 1'b0;
        repeat (12) cycle();
        chk("drained", out_valid, 1'b0);

        // Randomized traffic with varying consumer throttle.
        enable = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            case ($urandom_range(0, 2))
                0:       ready_pct = 10;
                1:       ready_pct = 50;
                default: ready_pct = 95;
            endcase
            for (int c = 0; c < 200; c++) begin
                enable         = ($urandom_range(0, 24) != 0);
                out_ready      = ($urandom_range(0, 99) < ready_pct);
                adc_data       = DATA_W'($urandom);
                clear_overflow = ($urandom_range(0, 7) == 0);
                reset          = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        reset          = 1'b0;
        clear_overflow = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
